sort_loader: RTL and testbench

//  Upstream stage of the sorter. Accepts a valid/ready stream of signed words and writes

---
 rtl/sort_pkg.sv | 20 ++
 rtl/sort_loader_if.sv | 49 ++++
 rtl/sort_ram_mux.sv | 23 ++
 rtl/sort_loader.sv | 131 +++++++++++++
 tb/tb_sort_loader.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sort_pkg.sv
// Shared definitions for the sorter front end: FSM state encoding and sorter limits.
// The localparams give the raw encodings; state_t wraps them for the loader FSM.
package sort_pkg;

  localparam logic [1:0] LOAD  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] SORT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  // The sorter cannot handle a region shorter than this.
  localparam int MIN_SORT_LEN = 2;

  typedef enum logic [1:0] {
    ST_LOAD  = LOAD,
    ST_ISSUE = ISSUE,
    ST_SORT  = SORT,
    ST_DONE  = DONE
  } state_t;

endpackage

// File: rtl/sort_loader_if.sv
// Bundle of the loader's stream, order, sorter-RAM and muxed-RAM signals.
// master is the environment (producer + sorter) side, slave is the loader side.
interface sort_loader_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
);

  logic                         in_valid;
  logic                         in_ready;
  logic signed [DATA_WIDTH-1:0] in_data;
  logic                         in_last;

  logic                         order_valid;
  logic                         order_busy;
  logic        [ADDR_WIDTH-1:0] order_start;
  logic        [DATA_WIDTH-1:0] order_len;

  logic        [ADDR_WIDTH-1:0] srt_ram_addr;
  logic                         srt_ram_write_req;
  logic        [DATA_WIDTH-1:0] srt_ram_write_data;

  logic        [ADDR_WIDTH-1:0] ram_addr;
  logic                         ram_write_req;
  logic        [DATA_WIDTH-1:0] ram_write_data;

  logic                         done;
  logic                         overflow;

  modport master (
    output in_valid, in_data, in_last,
    output order_busy,
    output srt_ram_addr, srt_ram_write_req, srt_ram_write_data,
    input  in_ready,
    input  order_valid, order_start, order_len,
    input  ram_addr, ram_write_req, ram_write_data,
    input  done, overflow
  );

  modport slave (
    input  in_valid, in_data, in_last,
    input  order_busy,
    input  srt_ram_addr, srt_ram_write_req, srt_ram_write_data,
    output in_ready,
    output order_valid, order_start, order_len,
    output ram_addr, ram_write_req, ram_write_data,
    output done, overflow
  );

endinterface

// File: rtl/sort_ram_mux.sv
// Combinational 2:1 select of the RAM {addr, write enable, data} port.
// sel_sorter hands the port to the sorter; otherwise the loader's write registers drive it.
module sort_ram_mux #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  sel_sorter,
  input  logic [ADDR_WIDTH-1:0] lw_addr,
  input  logic                  lw_we,
  input  logic [DATA_WIDTH-1:0] lw_data,
  input  logic [ADDR_WIDTH-1:0] srt_addr,
  input  logic                  srt_we,
  input  logic [DATA_WIDTH-1:0] srt_data,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_data
);

  assign ram_addr = sel_sorter ? srt_addr : lw_addr;
  assign ram_we   = sel_sorter ? srt_we   : lw_we;
  assign ram_data = sel_sorter ? srt_data : lw_data;

endmodule

// File: rtl/sort_loader.sv
// Buffers one set of streamed words into RAM from BASE_ADDR, issues a single sort order,
// waits for the sorter, then pulses done. Writes land one cycle after each accepted word.
module sort_loader
  import sort_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int BASE_ADDR  = 0,
  parameter int MAX_LEN    = 256
) (
  input logic          clk,
  input logic          rst,
  sort_loader_if.slave bus
);

  localparam logic [ADDR_WIDTH:0]   MAX_W  = (ADDR_WIDTH+1)'(MAX_LEN);
  localparam logic [ADDR_WIDTH-1:0] BASE_A = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] MIN_A  = ADDR_WIDTH'(MIN_SORT_LEN);

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   count;
  logic [ADDR_WIDTH-1:0]   len_q;
  logic [ADDR_WIDTH-1:0]   len_new;
  logic [ADDR_WIDTH-1:0]   lw_addr;
  logic [DATA_WIDTH-1:0]   lw_data;
  logic                    lw_we;
  logic                    in_ready_q;
  logic                    order_valid_q;
  logic                    done_q;
  logic                    overflow_q;
  logic                    handshake;
  logic                    room;
  logic                    stored;
  logic                    sel_sorter;

  assign handshake = bus.in_valid && in_ready_q;
  assign room      = {1'b0, count} < MAX_W;
  assign stored    = handshake && room;
  // Length of the set as it stands after this cycle's word, if any, is stored.
  assign len_new   = stored ? count + ADDR_WIDTH'(1) : count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_LOAD;
      count         <= '0;
      len_q         <= '0;
      lw_addr       <= '0;
      lw_data       <= '0;
      lw_we         <= 1'b0;
      in_ready_q    <= 1'b0;
      order_valid_q <= 1'b0;
      done_q        <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      lw_we  <= 1'b0;
      done_q <= 1'b0;
      case (state)
        ST_LOAD: begin
          in_ready_q <= 1'b1;
          if (stored) begin
            lw_we   <= 1'b1;
            lw_addr <= BASE_A + count;
            lw_data <= bus.in_data;
            count   <= count + ADDR_WIDTH'(1);
          end
          if (handshake && !room) begin
            overflow_q <= 1'b1;
          end
          // A dropped last word still closes the set.
          if (handshake && bus.in_last) begin
            len_q      <= len_new;
            in_ready_q <= 1'b0;
            if (len_new >= MIN_A) begin
              state         <= ST_ISSUE;
              order_valid_q <= 1'b1;
            end else begin
              state  <= ST_DONE;
              done_q <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (!bus.order_busy) begin
            order_valid_q <= 1'b0;
            state         <= ST_SORT;
          end
        end
        ST_SORT: begin
          if (!bus.order_busy) begin
            state  <= ST_DONE;
            done_q <= 1'b1;
          end
        end
        ST_DONE: begin
          count      <= '0;
          overflow_q <= 1'b0;
          in_ready_q <= 1'b1;
          state      <= ST_LOAD;
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.order_valid = order_valid_q;
  assign bus.order_start = BASE_A;
  assign bus.order_len   = DATA_WIDTH'(len_q);
  assign bus.done        = done_q;
  assign bus.overflow    = overflow_q;

  // The final loader write drains during ISSUE, so only SORT hands over the port.
  assign sel_sorter = (state == ST_SORT);

  sort_ram_mux #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ram_mux (
    .sel_sorter(sel_sorter),
    .lw_addr   (lw_addr),
    .lw_we     (lw_we),
    .lw_data   (lw_data),
    .srt_addr  (bus.srt_ram_addr),
    .srt_we    (bus.srt_ram_write_req),
    .srt_data  (bus.srt_ram_write_data),
    .ram_addr  (bus.ram_addr),
    .ram_we    (bus.ram_write_req),
    .ram_data  (bus.ram_write_data)
  );

endmodule

// File: tb/tb_sort_loader.sv
// Directed bench for sort_loader: a default instance plus a MAX_LEN=4 instance for overflow.
module tb_sort_loader;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  sort_loader_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) bus ();
  sort_loader_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) bus4 ();

  sort_loader #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .BASE_ADDR(0), .MAX_LEN(256)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  sort_loader #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .BASE_ADDR(0), .MAX_LEN(4)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4)
  );

  always #5 clk = ~clk;

  task automatic init_inputs();
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.order_busy = 1'b0;
    bus.srt_ram_addr = '0; bus.srt_ram_write_req = 1'b0; bus.srt_ram_write_data = '0;
    bus4.in_valid = 1'b0; bus4.in_data = '0; bus4.in_last = 1'b0; bus4.order_busy = 1'b0;
    bus4.srt_ram_addr = '0; bus4.srt_ram_write_req = 1'b0; bus4.srt_ram_write_data = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    init_inputs();
    #1;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", bus.in_ready); end
    total++; if ({bus.order_valid, bus.done, bus.overflow, bus.ram_write_req} !== 4'b0000) begin bad++;
      $display("FAIL reset_flags got=%b want=0000", {bus.order_valid, bus.done, bus.overflow, bus.ram_write_req}); end
    total++; if (bus.ram_addr !== 16'h0 || bus.order_len !== 16'h0 || bus.ram_write_data !== 16'h0) begin bad++;
      $display("FAIL reset_buses got addr=%h len=%h data=%h want 0", bus.ram_addr, bus.order_len, bus.ram_write_data); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%b want=1", bus.in_ready); end
    total++; if (bus4.in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready4 got=%b want=1", bus4.in_ready); end
  endtask

  task automatic test_load5();
    logic [15:0] w [5];
    w = '{16'h0003, 16'hFFFF, 16'h0007, 16'h0000, 16'h0002};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i > 0) begin
        total++; if (bus.ram_write_req !== 1'b1 || bus.ram_addr !== 16'(i-1) || bus.ram_write_data !== w[i-1]) begin bad++;
          $display("FAIL load5_write%0d got we=%b addr=%h data=%h want we=1 addr=%h data=%h",
                   i-1, bus.ram_write_req, bus.ram_addr, bus.ram_write_data, 16'(i-1), w[i-1]); end
      end
      bus.in_valid = 1'b1; bus.in_data = w[i]; bus.in_last = (i == 4);
    end
    @(negedge clk);
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    total++; if (bus.ram_write_req !== 1'b1 || bus.ram_addr !== 16'h4 || bus.ram_write_data !== 16'h0002) begin bad++;
      $display("FAIL load5_write4 got we=%b addr=%h data=%h want we=1 addr=0004 data=0002", bus.ram_write_req, bus.ram_addr, bus.ram_write_data); end
    total++; if (bus.order_valid !== 1'b1 || bus.order_len !== 16'd5 || bus.order_start !== 16'h0) begin bad++;
      $display("FAIL load5_order got valid=%b len=%0d start=%h want valid=1 len=5 start=0000", bus.order_valid, bus.order_len, bus.order_start); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL load5_issue_ready got=%b want=0", bus.in_ready); end
    @(negedge clk);
    total++; if (bus.order_valid !== 1'b0) begin bad++; $display("FAIL load5_order_drop got=%b want=0", bus.order_valid); end
    bus.order_busy = 1'b1; bus.srt_ram_addr = 16'h1234; bus.srt_ram_write_req = 1'b1; bus.srt_ram_write_data = 16'hBEEF;
    #1;
    total++; if (bus.ram_addr !== 16'h1234 || bus.ram_write_req !== 1'b1 || bus.ram_write_data !== 16'hBEEF) begin bad++;
      $display("FAIL load5_mux_srt got addr=%h we=%b data=%h want 1234 1 beef", bus.ram_addr, bus.ram_write_req, bus.ram_write_data); end
    @(negedge clk);
    bus.srt_ram_addr = 16'h0042; bus.srt_ram_write_req = 1'b0;
    #1;
    total++; if (bus.ram_addr !== 16'h0042 || bus.ram_write_req !== 1'b0 || bus.done !== 1'b0) begin bad++;
      $display("FAIL load5_mux_idle got addr=%h we=%b done=%b want 0042 0 0", bus.ram_addr, bus.ram_write_req, bus.done); end
    @(negedge clk);
    bus.order_busy = 1'b0; bus.srt_ram_addr = '0; bus.srt_ram_write_data = '0;
    @(negedge clk);
    total++; if (bus.done !== 1'b1 || bus.ram_write_req !== 1'b0) begin bad++;
      $display("FAIL load5_done got done=%b we=%b want done=1 we=0", bus.done, bus.ram_write_req); end
    @(negedge clk);
    total++; if (bus.done !== 1'b0 || bus.in_ready !== 1'b1) begin bad++;
      $display("FAIL load5_after_done got done=%b ready=%b want done=0 ready=1", bus.done, bus.in_ready); end
  endtask

  task automatic test_single();
    bus.in_valid = 1'b1; bus.in_data = 16'sd5; bus.in_last = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    total++; if (bus.ram_write_req !== 1'b1 || bus.ram_addr !== 16'h0 || bus.ram_write_data !== 16'h0005) begin bad++;
      $display("FAIL single_write got we=%b addr=%h data=%h want 1 0000 0005", bus.ram_write_req, bus.ram_addr, bus.ram_write_data); end
    total++; if (bus.done !== 1'b1 || bus.order_valid !== 1'b0) begin bad++;
      $display("FAIL single_done got done=%b order_valid=%b want done=1 order_valid=0", bus.done, bus.order_valid); end
    @(negedge clk);
    total++; if (bus.done !== 1'b0 || bus.order_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.ram_write_req !== 1'b0) begin bad++;
      $display("FAIL single_after got done=%b ov=%b ready=%b we=%b want 0 0 1 0", bus.done, bus.order_valid, bus.in_ready, bus.ram_write_req); end
  endtask

  task automatic test_busy_hold();
    bus.in_valid = 1'b1; bus.in_data = 16'sd10; bus.in_last = 1'b0;
    @(negedge clk);
    bus.in_data = 16'sd20; bus.in_last = 1'b1; bus.order_busy = 1'b1; bus.srt_ram_addr = 16'h7777;
    @(negedge clk);
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    total++; if (bus.ram_write_req !== 1'b1 || bus.ram_addr !== 16'h1 || bus.ram_write_data !== 16'd20 || bus.order_len !== 16'd2) begin bad++;
      $display("FAIL hold_last_write got we=%b addr=%h data=%h len=%0d want 1 0001 0014 2", bus.ram_write_req, bus.ram_addr, bus.ram_write_data, bus.order_len); end
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) @(negedge clk);
      total++; if (bus.order_valid !== 1'b1 || bus.ram_addr !== 16'h1) begin bad++;
        $display("FAIL hold_cycle%0d got order_valid=%b addr=%h want 1 0001", c, bus.order_valid, bus.ram_addr); end
    end
    bus.order_busy = 1'b0;
    @(negedge clk);
    total++; if (bus.order_valid !== 1'b0 || bus.ram_addr !== 16'h7777) begin bad++;
      $display("FAIL hold_accept got order_valid=%b addr=%h want 0 7777", bus.order_valid, bus.ram_addr); end
    bus.order_busy = 1'b1;
    @(negedge clk);
    bus.order_busy = 1'b0; bus.srt_ram_addr = '0;
    @(negedge clk);
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL hold_done got=%b want=1", bus.done); end
    @(negedge clk);
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL hold_done_pulse got=%b want=0", bus.done); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        total++; if (bus4.ram_write_req !== (i <= 4) || (i <= 4 && bus4.ram_addr !== 16'(i-1))) begin bad++;
          $display("FAIL ovf_write%0d got we=%b addr=%h want we=%b addr=%h", i-1, bus4.ram_write_req, bus4.ram_addr, (i <= 4), 16'(i-1)); end
        total++; if (bus4.overflow !== (i >= 5)) begin bad++;
          $display("FAIL ovf_flag%0d got=%b want=%b", i-1, bus4.overflow, (i >= 5)); end
      end
      bus4.in_valid = 1'b1; bus4.in_data = 16'(11 + i); bus4.in_last = (i == 5);
      @(negedge clk);
    end
    bus4.in_valid = 1'b0; bus4.in_last = 1'b0;
    total++; if (bus4.ram_write_req !== 1'b0 || bus4.overflow !== 1'b1) begin bad++;
      $display("FAIL ovf_write5 got we=%b ovf=%b want 0 1", bus4.ram_write_req, bus4.overflow); end
    total++; if (bus4.order_valid !== 1'b1 || bus4.order_len !== 16'd4) begin bad++;
      $display("FAIL ovf_order got valid=%b len=%0d want 1 4", bus4.order_valid, bus4.order_len); end
    @(negedge clk);
    bus4.order_busy = 1'b1;
    @(negedge clk);
    bus4.order_busy = 1'b0;
    @(negedge clk);
    total++; if (bus4.done !== 1'b1 || bus4.overflow !== 1'b1) begin bad++;
      $display("FAIL ovf_done got done=%b ovf=%b want 1 1", bus4.done, bus4.overflow); end
    @(negedge clk);
    total++; if (bus4.done !== 1'b0 || bus4.overflow !== 1'b0 || bus4.in_ready !== 1'b1) begin bad++;
      $display("FAIL ovf_clear got done=%b ovf=%b ready=%b want 0 0 1", bus4.done, bus4.overflow, bus4.in_ready); end
  endtask

  task automatic test_random_gaps();
    int   sent = 0;
    int   writes = 0;
    int   exp_addr = 0;
    logic prev_hs = 1'b0;
    logic fin = 1'b0;
    logic v;
    for (int c = 0; c < 400 && !fin; c++) begin
      @(negedge clk);
      total++; if (bus.ram_write_req !== prev_hs) begin bad++;
        $display("FAIL gaps_we cycle%0d got=%b want=%b", c, bus.ram_write_req, prev_hs); end
      if (bus.ram_write_req === 1'b1) writes++;
      if (prev_hs) begin
        total++; if (bus.ram_addr !== 16'(exp_addr) || bus.ram_write_data !== 16'(100 + exp_addr)) begin bad++;
          $display("FAIL gaps_addr got addr=%h data=%h want addr=%h data=%h", bus.ram_addr, bus.ram_write_data, 16'(exp_addr), 16'(100 + exp_addr)); end
        exp_addr++;
      end
      if (sent == 12) begin
        fin = 1'b1;
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
      end else begin
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL gaps_ready got=%b want=1", bus.in_ready); end
        v = 1'($urandom_range(0, 1));
        bus.in_valid = v; bus.in_data = 16'(100 + sent); bus.in_last = v && (sent == 11);
        prev_hs = v;
        if (v) sent++;
      end
    end
    total++; if (!fin) begin bad++; $display("FAIL gaps_timeout sent=%0d want 12", sent); end
    total++; if (writes != 12) begin bad++; $display("FAIL gaps_write_count got=%0d want=12", writes); end
    total++; if (bus.order_valid !== 1'b1 || bus.order_len !== 16'd12) begin bad++;
      $display("FAIL gaps_order got valid=%b len=%0d want 1 12", bus.order_valid, bus.order_len); end
    @(negedge clk);
    bus.order_busy = 1'b1; bus.srt_ram_addr = 16'h0099;
    #1;
    total++; if (bus.ram_write_req !== 1'b0 || bus.ram_addr !== 16'h0099) begin bad++;
      $display("FAIL gaps_sort_nowrite got we=%b addr=%h want 0 0099", bus.ram_write_req, bus.ram_addr); end
    @(negedge clk);
    bus.order_busy = 1'b0; bus.srt_ram_addr = '0;
    @(negedge clk);
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL gaps_done got=%b want=1", bus.done); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_sort();
    bus.in_valid = 1'b1; bus.in_data = 16'sd1; bus.in_last = 1'b0;
    @(negedge clk);
    bus.in_data = 16'sd2; bus.in_last = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    @(negedge clk);
    bus.order_busy = 1'b1; bus.srt_ram_addr = 16'h0055; bus.srt_ram_write_req = 1'b1; bus.srt_ram_write_data = 16'h1111;
    #1;
    total++; if (bus.ram_write_req !== 1'b1 || bus.ram_addr !== 16'h0055) begin bad++;
      $display("FAIL rstsort_in_sort got we=%b addr=%h want 1 0055", bus.ram_write_req, bus.ram_addr); end
    #1 rst = 1'b1;
    #1;
    total++; if ({bus.in_ready, bus.order_valid, bus.done, bus.overflow, bus.ram_write_req} !== 5'b0) begin bad++;
      $display("FAIL rstsort_flags got=%b want=00000", {bus.in_ready, bus.order_valid, bus.done, bus.overflow, bus.ram_write_req}); end
    total++; if (bus.ram_addr !== 16'h0 || bus.ram_write_data !== 16'h0 || bus.order_len !== 16'h0) begin bad++;
      $display("FAIL rstsort_buses got addr=%h data=%h len=%h want 0", bus.ram_addr, bus.ram_write_data, bus.order_len); end
    bus.order_busy = 1'b0; bus.srt_ram_addr = '0; bus.srt_ram_write_req = 1'b0; bus.srt_ram_write_data = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rstsort_ready got=%b want=1", bus.in_ready); end
    bus.in_valid = 1'b1; bus.in_data = 16'sd9; bus.in_last = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    total++; if (bus.ram_write_req !== 1'b1 || bus.ram_addr !== 16'h0 || bus.ram_write_data !== 16'h0009 || bus.done !== 1'b1) begin bad++;
      $display("FAIL rstsort_restart got we=%b addr=%h data=%h done=%b want 1 0000 0009 1", bus.ram_write_req, bus.ram_addr, bus.ram_write_data, bus.done); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_load5();
    test_single();
    test_busy_hold();
    test_overflow();
    test_random_gaps();
    test_reset_mid_sort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
